wb_instr_ram_bridge: RTL

- Wishbone classic slave in the Caravel user project area.
- Gives the management SoC read/write access to the rvj1 core's instruction SRAM, so firmware can load and verify core code over Wishbone.
- Arbitrates the single SRAM port between Wishbone (priority) and the rvj1 instruction-fetch port.
- Sits directly downstream of the management-side Wishbone traffic that the instr_ram_rw system test exercises.

---
 rtl/wb_instr_ram_bridge_pkg.sv | 25 ++
 rtl/wb_instr_ram_bridge.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_instr_ram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_ram_pkg
// Brief   : Shared types and constants for the Wishbone instruction-RAM bridge
//           (FSM state encoding, SRAM data/select widths, default addresses).
// Revision: 1.0 - initial release
// ============================================================================
package instr_ram_pkg;

   localparam int RAM_DATA_W = 32;
   localparam int RAM_SEL_W  = 4;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
   localparam logic [31:0] DEF_CTRL_ADDR = 32'h3000_8000;

   // Wishbone-side transaction sequencer states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      ACK     = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_instr_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module  : wb_instr_ram_bridge
// Brief   : Wishbone classic slave giving the management SoC read/write access
//           to the rvj1 instruction SRAM. The single SRAM port is shared with
//           the core fetch port; a Wishbone access in ACCESS always wins.
//           Optional macro INSTR_RAM_CORE_HOLD_EN adds a control word at
//           CTRL_ADDR whose bit 0 holds the core in reset (reset value 1).
// Revision: 1.0 - initial release
// ============================================================================
module wb_instr_ram_bridge
   import instr_ram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] CTRL_ADDR  = DEF_CTRL_ADDR
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rstn_i,
   // Wishbone slave
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_we_i,
   input  logic [RAM_SEL_W-1:0]   wbs_sel_i,
   input  logic [31:0]            wbs_adr_i,
   input  logic [RAM_DATA_W-1:0]  wbs_dat_i,
   output logic                   wbs_ack_o,
   output logic [RAM_DATA_W-1:0]  wbs_dat_o,
   // Core fetch port
   input  logic                   core_req_i,
   input  logic [ADDR_WIDTH-1:0]  core_addr_i,
   output logic                   core_gnt_o,
   output logic                   core_rvalid_o,
   output logic [RAM_DATA_W-1:0]  core_rdata_o,
   output logic                   core_hold_o,
   // SRAM port
   output logic                   ram_csb_o,
   output logic                   ram_web_o,
   output logic [RAM_SEL_W-1:0]   ram_wmask_o,
   output logic [ADDR_WIDTH-1:0]  ram_addr_o,
   output logic [RAM_DATA_W-1:0]  ram_din_o,
   input  logic [RAM_DATA_W-1:0]  ram_dout_i
);

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_adr;
   logic [RAM_DATA_W-1:0]   r_dat;
   logic [RAM_SEL_W-1:0]    r_sel;
   logic                    r_we;
   logic                    r_ctrl;
   logic                    r_ack;
   logic [RAM_DATA_W-1:0]   r_rdata;
   logic                    r_rvalid;

   logic                    w_req;
   logic                    w_ram_hit;
   logic                    w_ctrl_hit;
   logic                    w_hit;
   logic                    w_hold;
   logic                    w_core_gnt;
   logic                    w_wb_ram;
   logic [RAM_DATA_W-1:0]   w_ctrl_rdata;
   logic                    w_unused;

   // Byte-lane bits of the address carry no information for word accesses
   assign w_unused = ^wbs_adr_i[1:0];

   assign w_req     = wbs_cyc_i & wbs_stb_i;
   assign w_ram_hit = w_req & (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

`ifdef INSTR_RAM_CORE_HOLD_EN
   logic r_hold;

   assign w_ctrl_hit = w_req & (wbs_adr_i[31:2] == CTRL_ADDR[31:2]);
   assign w_hold     = r_hold;

   // Hold register: written through the normal FSM path while in ACCESS
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_hold <= 1'b1;
      end else if ((r_state == ACCESS) && r_ctrl && r_we && r_sel[0]) begin
         r_hold <= r_dat[0];
      end
   end
`else
   logic w_unused_ctrl;

   assign w_ctrl_hit    = 1'b0;
   assign w_hold        = 1'b0;
   assign w_unused_ctrl = ^CTRL_ADDR;
`endif

   // A control-word hit takes precedence should CTRL_ADDR ever fall in the window
   assign w_hit        = w_ram_hit | w_ctrl_hit;
   assign w_ctrl_rdata = {{(RAM_DATA_W-1){1'b0}}, w_hold};

   // Wishbone sequencer: latch request, drive SRAM, capture read data, ack
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_state <= IDLE;
         r_adr   <= '0;
         r_dat   <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_ctrl  <= 1'b0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_adr   <= wbs_adr_i[ADDR_WIDTH+1:2];
                  r_dat   <= wbs_dat_i;
                  r_sel   <= wbs_sel_i;
                  r_we    <= wbs_we_i;
                  r_ctrl  <= w_ctrl_hit;
                  r_state <= ACCESS;
               end
            end
            ACCESS: begin
               if (r_we) begin
                  r_ack   <= 1'b1;
                  r_state <= ACK;
               end else begin
                  r_state <= CAPTURE;
               end
            end
            CAPTURE: begin
               r_rdata <= r_ctrl ? w_ctrl_rdata : ram_dout_i;
               r_ack   <= 1'b1;
               r_state <= ACK;
            end
            ACK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Fetch data is valid the cycle after a grant, matching SRAM read latency
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_core_gnt;
      end
   end

   // Core may use the port in every state but ACCESS; no grant while held
   assign w_core_gnt = core_req_i & (r_state != ACCESS) & ~w_hold;
   assign w_wb_ram   = (r_state == ACCESS) & ~r_ctrl;

   // SRAM port mux: Wishbone in ACCESS, otherwise a granted fetch, else idle
   always_comb begin
      ram_csb_o   = 1'b1;
      ram_web_o   = 1'b1;
      ram_wmask_o = '0;
      ram_addr_o  = r_adr;
      if (w_wb_ram) begin
         ram_csb_o   = 1'b0;
         ram_web_o   = ~r_we;
         ram_wmask_o = r_we ? r_sel : '0;
      end else if (w_core_gnt) begin
         ram_csb_o  = 1'b0;
         ram_addr_o = core_addr_i;
      end
   end

   assign ram_din_o     = r_dat;
   assign wbs_ack_o     = r_ack & wbs_cyc_i;
   assign wbs_dat_o     = r_rdata;
   assign core_gnt_o    = w_core_gnt;
   assign core_rvalid_o = r_rvalid;
   assign core_rdata_o  = ram_dout_i;
   assign core_hold_o   = w_hold;

endmodule
`default_nettype wire
